// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: register file for the decode stage.
// It has two write ports (port 0 is ALU writeback and has priority over port 1,
// load writeback) and two combinational read ports.
// A read returns the value being written in the same cycle (write-to-read bypass).
// A busy bit per register records an outstanding write, for hazard detection.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we0,
    input  logic [ADDR_W-1:0]      waddr0,
    input  logic [DATA_W-1:0]      wdata0,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      waddr1,
    input  logic [DATA_W-1:0]      wdata1,
    input  logic [ADDR_W-1:0]      raddr_a,
    input  logic [ADDR_W-1:0]      raddr_b,
    output logic [DATA_W-1:0]      rdata_a,
    output logic [DATA_W-1:0]      rdata_b,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    logic wr0_ok, wr1_ok, set_ok;
    logic hit0_a, hit1_a, hit0_b, hit1_b;

    // Qualify the write and issue strobes.
    // A write or issue to a hardwired r0 is dropped.
    // Port 1 loses a same-address collision with port 0.
    always_comb begin
        wr0_ok = we0 && !(ZR && waddr0 == '0);
        wr1_ok = we1 && !(ZR && waddr1 == '0) && !(we0 && waddr0 == waddr1);
        set_ok = issue_valid && !(ZR && issue_rd == '0);
        hit0_a = we0 && (waddr0 == raddr_a);
        hit1_a = we1 && (waddr1 == raddr_a);
        hit0_b = we0 && (waddr0 == raddr_b);
        hit1_b = we1 && (waddr1 == raddr_b);
    end

    // Register array write.
    // The whole array clears asynchronously, so a pending write is lost if reset hits its edge.
    // NOTE: the array has a reset on purpose. The reset state must read as all zeros,
    // so it is built from flops rather than an inferred RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr1_ok) mem[waddr1] <= wdata1;
            if (wr0_ok) mem[waddr0] <= wdata0;
        end
    end

    // Next scoreboard state.
    // Writebacks clear their bit, then an issue sets its bit.
    // The set wins on the same register because the new producer is still pending.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (we0 && waddr0 == ADDR_W'(i)) busy_next[i] = 1'b0;
            if (we1 && waddr1 == ADDR_W'(i)) busy_next[i] = 1'b0;
            if (set_ok && issue_rd == ADDR_W'(i)) busy_next[i] = 1'b1;
        end
        if (ZR) busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    // NOTE: clocked state uses non-blocking assignments so that every flop samples its pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // Read port A.
    // Priority order: hardwired zero, then port 0 bypass, then port 1 bypass, then the array.
    always_comb begin
        if (ZR && raddr_a == '0) rdata_a = '0;
        else if (hit0_a)         rdata_a = wdata0;
        else if (hit1_a)         rdata_a = wdata1;
        else                     rdata_a = mem[raddr_a];
    end

    // Read port B, with the same priority as port A.
    always_comb begin
        if (ZR && raddr_b == '0) rdata_b = '0;
        else if (hit0_b)         rdata_b = wdata0;
        else if (hit1_b)         rdata_b = wdata1;
        else                     rdata_b = mem[raddr_b];
    end

    // Operand busy flags.
    // An operand that is forwarded this cycle never reports busy.
    always_comb begin
        busy_a   = busy[raddr_a] && !(hit0_a || hit1_a);
        busy_b   = busy[raddr_b] && !(hit0_b || hit1_b);
        busy_vec = busy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed scenarios followed by random traffic.
// Every output is compared against a behavioural model of the register file.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1, issue_valid;
    logic [AW-1:0] waddr0, waddr1, raddr_a, raddr_b, issue_rd;
    logic [DW-1:0] wdata0, wdata1, rdata_a, rdata_b;
    logic          busy_a, busy_b;
    logic [N-1:0]  busy_vec;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] mem_m [N];
    bit   [N-1:0]  busy_m;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0)                return '0;
        if (we0 && waddr0 == a)    return wdata0;
        if (we1 && waddr1 == a)    return wdata1;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        return busy_m[a] && !((we0 && waddr0 == a) || (we1 && waddr1 == a));
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) mem_m[i] = '0;
        busy_m = '0;
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic model_edge();
        bit [N-1:0] nb;
        if (rst) begin
            reset_model();
        end else begin
            nb = busy_m;
            if (we0) nb[waddr0] = 1'b0;
            if (we1) nb[waddr1] = 1'b0;
            if (issue_valid) nb[issue_rd] = 1'b1;
            nb[0] = 1'b0;
            if (we1 && waddr1 != 0 && !(we0 && waddr0 == waddr1)) mem_m[waddr1] = wdata1;
            if (we0 && waddr0 != 0) mem_m[waddr0] = wdata0;
            busy_m = nb;
        end
    endtask

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        issue_valid = 0; issue_rd = '0;
        raddr_a = '0; raddr_b = '0;
    endtask

    // Called just after a negedge with the inputs set.
    // Checks the combinational outputs, clocks one edge, checks busy_vec, and returns at the next negedge.
    task automatic step(input string tag);
        #1;
        check({tag, ".rda"}, rdata_a, exp_rd(raddr_a));
        check({tag, ".rdb"}, rdata_b, exp_rd(raddr_b));
        check({tag, ".bsa"}, 32'(busy_a), 32'(exp_busy(raddr_a)));
        check({tag, ".bsb"}, 32'(busy_b), 32'(exp_busy(raddr_b)));
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".bv"}, busy_vec, busy_m);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        reset_model();
        #2;
        // Reset with r0 written via port 0; bypass to r5 via port 1 is still live.
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF; raddr_a = 5'd0;
        we1 = 1; waddr1 = 5'd5; wdata1 = 32'h0000CAFE; raddr_b = 5'd5;
        #1;
        check("rst.r0",  rdata_a, 32'h0);
        check("rst.bv",  busy_vec, 32'h0);
        check("rst.byp", rdata_b, 32'h0000CAFE);
        check("rst.bsa", 32'(busy_a), 32'h0);
        @(negedge clk);
        step("rst");
        idle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(N - 1 - i);
            #1;
            check($sformatf("clr.a%0d", i), rdata_a, 32'h0);
            check($sformatf("clr.b%0d", i), rdata_b, 32'h0);
            @(negedge clk);
        end

        // Bypass in the write cycle, then the stored value after the edge.
        idle();
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'h12345678; raddr_a = 5'd5;
        #1 check("byp.now", rdata_a, 32'h12345678);
        step("byp");
        idle(); raddr_a = 5'd5;
        #1 check("byp.after", rdata_a, 32'h12345678);
        step("byp2");

        // Dual write to r7: port 0 wins.
        idle();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h0000BBBB; raddr_a = 5'd7;
        #1 check("col.now", rdata_a, 32'hAAAA0000);
        step("col");
        idle(); raddr_b = 5'd7;
        #1 check("col.after", rdata_b, 32'hAAAA0000);
        step("col2");

        // Scoreboard lifecycle on r9.
        idle(); issue_valid = 1; issue_rd = 5'd9;
        step("sb.iss");
        for (int k = 0; k < 3; k++) begin
            idle(); raddr_b = 5'd9;
            #1 check($sformatf("sb.hold%0d", k), 32'(busy_b), 32'h1);
            step("sb.idle");
        end
        idle(); raddr_b = 5'd9; we1 = 1; waddr1 = 5'd9; wdata1 = 32'h55;
        #1;
        check("sb.wb.busy", 32'(busy_b), 32'h0);
        check("sb.wb.data", rdata_b, 32'h55);
        step("sb.wb");
        check("sb.bv9", 32'(busy_vec[9]), 32'h0);

        // Issue and writeback of r3 on the same edge: the set wins.
        idle(); issue_valid = 1; issue_rd = 5'd3; we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1;
        step("race");
        check("race.bv3", 32'(busy_vec[3]), 32'h1);

        // Asynchronous reset between clock edges.
        idle(); we0 = 1; waddr0 = 5'd4; wdata0 = 32'h99;
        step("ar.wr");
        idle(); issue_valid = 1; issue_rd = 5'd4;
        step("ar.iss");
        check("ar.bv4", 32'(busy_vec[4]), 32'h1);
        idle(); raddr_a = 5'd4;
        #1 check("ar.pre", rdata_a, 32'h99);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar.bv",  busy_vec, 32'h0);
        check("ar.rd4", rdata_a, 32'h0);
        reset_model();
        #1 rst = 1'b0;
        @(negedge clk);

        // Random traffic over a narrow address range, to provoke collisions and hazards.
        for (int c = 0; c < 400; c++) begin
            we0         = ($urandom_range(0, 99) < 40);
            waddr0      = AW'($urandom_range(0, 7));
            wdata0      = $urandom;
            we1         = ($urandom_range(0, 99) < 40);
            waddr1      = AW'($urandom_range(0, 7));
            wdata1      = $urandom;
            issue_valid = ($urandom_range(0, 99) < 50);
            issue_rd    = AW'($urandom_range(0, 7));
            raddr_a     = AW'($urandom_range(0, 7));
            raddr_b     = AW'($urandom_range(0, 7));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
